// File: rtl/tag_mem_serializer_pkg.sv
// Shared definitions for the tag memory serializer: bank encodings, PC length
// field, FSM state encoding and the default bank depth.
package tag_mem_serializer_pkg;

    localparam int WORDS_PER_BANK_DEF = 16;
    localparam int PC_LEN_HI          = 15;
    localparam int PC_LEN_LO          = 11;
    localparam int PC_WORD_ADDR       = 1;

    typedef enum logic [1:0] {
        BANK_RESERVED = 2'd0,
        BANK_EPC      = 2'd1,
        BANK_TID      = 2'd2,
        BANK_USER     = 2'd3
    } bank_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // EPC reply covers the PC word itself plus the EPC words it announces.
    function automatic logic [5:0] epc_reply_words(input logic [15:0] pc);
        return {1'b0, pc[PC_LEN_HI:PC_LEN_LO]} + 6'd1;
    endfunction

endpackage

// File: rtl/tag_mem_array.sv
// 4-bank x WORDS_PER_BANK x 16-bit tag register file: one combinational read
// port, one synchronous write port, PC word preloaded on reset.
module tag_mem_array
    import tag_mem_serializer_pkg::*;
#(
    parameter int          WORDS_PER_BANK = WORDS_PER_BANK_DEF,
    parameter int          ADDR_W         = 4,
    parameter logic [15:0] PC_RESET       = 16'h3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        wbank,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [1:0]        rbank,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [4][WORDS_PER_BANK];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                for (int w = 0; w < WORDS_PER_BANK; w++) begin
                    mem[b][w] <= (b == int'(BANK_EPC) && w == PC_WORD_ADDR) ? PC_RESET : 16'h0000;
                end
            end
        end else if (we) begin
            mem[wbank][waddr] <= wdata;
        end
    end

    assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/tag_mem_serializer.sv
// Tag memory array plus MSB-first payload serializer for EPC and READ replies.
// Optional macro MEM_HANDLE_APPEND_EN appends the handle word to READ replies.
module tag_mem_serializer
    import tag_mem_serializer_pkg::*;
#(
    parameter int          WORDS_PER_BANK = WORDS_PER_BANK_DEF,
    parameter int          ADDR_W         = 4,
    parameter logic [15:0] PC_RESET       = 16'h3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        epc_mode,
    input  logic [1:0]  readwritebank,
    input  logic [7:0]  readwriteptr,
    input  logic [7:0]  readwords,
    input  logic [15:0] writedataout,
    input  logic        epc_data_ready,
    input  logic        membitclk,
    input  logic [15:0] handle,
    output logic        membitsrc,
    output logic        memdatadone,
    output logic        mem_error
);

`ifdef MEM_HANDLE_APPEND_EN
    localparam bit APPEND_EN = 1'b1;
`else
    localparam bit APPEND_EN = 1'b0;
`endif

    localparam logic [8:0] WPB9 = 9'(WORDS_PER_BANK);

    state_e            state, state_next;
    logic              membitclk_q, tx_q, wr_q;
    logic              bit_rise, tx_rise, wr_rise;
    logic [1:0]        cur_bank;
    logic [ADDR_W-1:0] cur_addr;
    logic [8:0]        remaining;
    logic [3:0]        bitcnt;
    logic              append_pending;
    logic [15:0]       shreg;
    logic [1:0]        rbank;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       rdata;
    logic              ptr_ok, rd_range_err, setup_err;
    logic [8:0]        rd_len;
    logic [15:0]       handle_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            membitclk_q <= 1'b0;
            tx_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            membitclk_q <= membitclk;
            tx_q        <= tx_enable;
            wr_q        <= epc_data_ready;
        end
    end

    assign bit_rise = membitclk & ~membitclk_q;
    assign tx_rise  = tx_enable & ~tx_q;
    assign wr_rise  = epc_data_ready & ~wr_q;

    assign ptr_ok       = {1'b0, readwriteptr} < WPB9;
    assign rd_range_err = !ptr_ok || (({1'b0, readwriteptr} + {1'b0, readwords}) > WPB9);
    assign rd_len       = (readwords == 8'd0) ? (WPB9 - {1'b0, readwriteptr}) : {1'b0, readwords};
    assign setup_err    = !epc_mode && rd_range_err;
    assign handle_word  = APPEND_EN ? handle : 16'h0000;

    // SETUP borrows the read port to fetch the PC length field.
    assign rbank = (state == ST_SETUP) ? 2'(BANK_EPC) : cur_bank;
    assign raddr = (state == ST_SETUP) ? ADDR_W'(PC_WORD_ADDR) : cur_addr;

    tag_mem_array #(
        .WORDS_PER_BANK (WORDS_PER_BANK),
        .ADDR_W         (ADDR_W),
        .PC_RESET       (PC_RESET)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (wr_rise && ptr_ok),
        .wbank (readwritebank),
        .waddr (readwriteptr[ADDR_W-1:0]),
        .wdata (writedataout),
        .rbank (rbank),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        membitsrc   = 1'b0;
        memdatadone = 1'b0;
        if (!tx_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (tx_rise) state_next = ST_SETUP;
                ST_SETUP: state_next = setup_err ? ST_DONE : ST_FETCH;
                ST_FETCH: state_next = ST_SHIFT;
                ST_SHIFT: begin
                    if (bit_rise && bitcnt == 4'd0) begin
                        state_next = (remaining != 9'd0 || append_pending) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
        membitsrc   = (state == ST_SHIFT) ? shreg[15] : 1'b0;
        memdatadone = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_bank       <= 2'd0;
            cur_addr       <= '0;
            remaining      <= 9'd0;
            bitcnt         <= 4'd0;
            append_pending <= 1'b0;
            mem_error      <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: begin
                    mem_error <= setup_err;
                    if (epc_mode) begin
                        cur_bank       <= 2'(BANK_EPC);
                        cur_addr       <= ADDR_W'(PC_WORD_ADDR);
                        remaining      <= 9'(epc_reply_words(rdata));
                        append_pending <= 1'b0;
                    end else begin
                        cur_bank       <= readwritebank;
                        cur_addr       <= readwriteptr[ADDR_W-1:0];
                        remaining      <= rd_len;
                        append_pending <= APPEND_EN;
                    end
                end
                ST_FETCH: begin
                    bitcnt <= 4'd15;
                    if (remaining != 9'd0) begin
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
                    end else begin
                        append_pending <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_rise && bitcnt != 4'd0) bitcnt <= bitcnt - 4'd1;
                end
                default: ;
            endcase
            // A dropped write flags the error even in the cycle SETUP clears it.
            if (wr_rise && !ptr_ok) mem_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FETCH) begin
            shreg <= (remaining != 9'd0) ? rdata : handle_word;
        end else if (state == ST_SHIFT && bit_rise) begin
            shreg <= {shreg[14:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_tag_mem_serializer.sv
// Scoreboard bench for tag_mem_serializer: directed replies push expected bits,
// a monitor pops and compares on every membitclk rising edge.
module tb_tag_mem_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b0;
    logic        epc_mode = 1'b0;
    logic [1:0]  readwritebank = 2'd0;
    logic [7:0]  readwriteptr = 8'd0;
    logic [7:0]  readwords = 8'd0;
    logic [15:0] writedataout = 16'h0;
    logic        epc_data_ready = 1'b0;
    logic        membitclk = 1'b0;
    logic [15:0] handle = 16'h1234;
    logic        membitsrc, memdatadone, mem_error;

    int checks = 0;
    int errors = 0;
    int bit_idx = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    tag_mem_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .tx_enable      (tx_enable),
        .epc_mode       (epc_mode),
        .readwritebank  (readwritebank),
        .readwriteptr   (readwriteptr),
        .readwords      (readwords),
        .writedataout   (writedataout),
        .epc_data_ready (epc_data_ready),
        .membitclk      (membitclk),
        .handle         (handle),
        .membitsrc      (membitsrc),
        .memdatadone    (memdatadone),
        .mem_error      (mem_error)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        logic e;
        forever begin
            @(posedge membitclk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bit_extra actual=%0b required=none t=%0t", membitsrc, $time);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("bit%0d", bit_idx), 32'(membitsrc), 32'(e));
            end
            bit_idx++;
        end
    end

    task automatic push_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) exp_q.push_back(w[i]);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) membitclk = 1'b1;
            @(negedge clk);
            @(negedge clk) membitclk = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic last_bit(input string nm);
        @(negedge clk) membitclk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check(nm, 32'(memdatadone), 32'd1);
        @(negedge clk) membitclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_reply(input int n, input string nm);
        send_bits(n - 1);
        check({nm, "_notdone"}, 32'(memdatadone), 32'd0);
        last_bit({nm, "_done"});
    endtask

    task automatic start_reply(input logic epc, input logic [1:0] bank,
                               input logic [7:0] ptr, input logic [7:0] words);
        @(negedge clk);
        epc_mode      = epc;
        readwritebank = bank;
        readwriteptr  = ptr;
        readwords     = words;
        tx_enable     = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic stop_reply();
        @(negedge clk) tx_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic write_word(input logic [1:0] bank, input logic [7:0] ptr, input logic [15:0] d);
        @(negedge clk);
        readwritebank  = bank;
        readwriteptr   = ptr;
        writedataout   = d;
        epc_data_ready = 1'b1;
        @(negedge clk) epc_data_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_membitsrc", 32'(membitsrc), 32'd0);
        check("rst_done", 32'(memdatadone), 32'd0);
        check("rst_error", 32'(mem_error), 32'd0);

        // Default EPC reply: PC 0x3000 followed by six zero words.
        push_bits(16'h3000, 16);
        for (int i = 0; i < 6; i++) push_bits(16'h0000, 16);
        start_reply(1'b1, 2'd0, 8'd0, 8'd0);
        run_reply(112, "epc112");
        check("epc112_err", 32'(mem_error), 32'd0);
        stop_reply();
        check("epc_abort_done", 32'(memdatadone), 32'd0);

        // Write then single-word READ.
        write_word(2'd3, 8'd2, 16'hA5C3);
        push_bits(16'hA5C3, 16);
        start_reply(1'b0, 2'd3, 8'd2, 8'd1);
        run_reply(16, "rd1");
        check("rd1_err", 32'(mem_error), 32'd0);
        stop_reply();

        // Out-of-range write is dropped and flags the error.
        write_word(2'd3, 8'd20, 16'hFFFF);
        check("wr_oor_err", 32'(mem_error), 32'd1);

        // READ to end of bank from ptr 14.
        write_word(2'd2, 8'd14, 16'h8001);
        write_word(2'd2, 8'd15, 16'h7FFE);
        push_bits(16'h8001, 16);
        push_bits(16'h7FFE, 16);
        start_reply(1'b0, 2'd2, 8'd14, 8'd0);
        check("rd_end_err_clr", 32'(mem_error), 32'd0);
        run_reply(32, "rd_end");
        stop_reply();

        // Range error: ptr 14 + 3 words overruns the bank.
        start_reply(1'b0, 2'd2, 8'd14, 8'd3);
        check("rng_done", 32'(memdatadone), 32'd1);
        check("rng_err", 32'(mem_error), 32'd1);
        check("rng_bit", 32'(membitsrc), 32'd0);
        stop_reply();

        // Abort after 5 bits, then restart from the word start.
        push_bits(16'hA5C3, 5);
        start_reply(1'b0, 2'd3, 8'd2, 8'd1);
        send_bits(5);
        stop_reply();
        check("abort_done", 32'(memdatadone), 32'd0);
        check("abort_bit", 32'(membitsrc), 32'd0);
        push_bits(16'hA5C3, 16);
        start_reply(1'b0, 2'd3, 8'd2, 8'd1);
        run_reply(16, "restart");
        stop_reply();

        // Rewriting PC mid-reply leaves the current length alone.
        push_bits(16'h3000, 16);
        for (int i = 0; i < 6; i++) push_bits(16'h0000, 16);
        start_reply(1'b1, 2'd0, 8'd0, 8'd0);
        send_bits(20);
        write_word(2'd1, 8'd1, 16'h2000);
        send_bits(91);
        check("epc_mid_notdone", 32'(memdatadone), 32'd0);
        last_bit("epc_mid_done");
        stop_reply();
        push_bits(16'h2000, 16);
        for (int i = 0; i < 4; i++) push_bits(16'h0000, 16);
        start_reply(1'b1, 2'd0, 8'd0, 8'd0);
        run_reply(80, "epc80");
        check("epc80_err", 32'(mem_error), 32'd0);
        stop_reply();

        // Handle append (only when the feature is built in).
        push_bits(16'hA5C3, 16);
`ifdef MEM_HANDLE_APPEND_EN
        push_bits(16'h1234, 16);
        start_reply(1'b0, 2'd3, 8'd2, 8'd1);
        run_reply(32, "hdl");
`else
        start_reply(1'b0, 2'd3, 8'd2, 8'd1);
        run_reply(16, "hdl");
`endif
        stop_reply();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
